// File: rtl/core_issue_ctrl.sv
// core_issue_ctrl: instruction sequencer in front of the CORE ALU/register datapath.
// Upstream instructions are buffered in a small FIFO. They are issued to the datapath
// one at a time, and each result is retired with a one-cycle strobe. If the datapath
// never signals completion, the sequencer raises a sticky error and moves on.

module core_issue_ctrl #(
    parameter int DEPTH   = 4,   // FIFO entries, power of two, >= 2
    parameter int INST_W  = 21,  // instruction width, opcode in the top three bits
    parameter int TIMEOUT = 16   // WAIT cycles before an issued instruction is abandoned
) (
    input  logic                       i_clk,
    input  logic                       i_rsn,
    input  logic [INST_W-1:0]          i_inst,
    input  logic                       i_valid,
    output logic                       o_ready,
    output logic [INST_W-1:0]          o_issue_inst,
    output logic                       o_issue_valid,
    input  logic                       i_exec_done,
    input  logic [5:0]                 i_data,
    input  logic [3:0]                 i_flag,
    output logic [5:0]                 o_res_data,
    output logic [3:0]                 o_res_flag,
    output logic                       o_res_valid,
    output logic                       o_busy,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TMR_W = $clog2(TIMEOUT);

    localparam logic [2:0]       OPC_NOP  = 3'b000;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RETIRE
    } state_t;

    // FIFO storage and bookkeeping
    logic [INST_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              push;
    logic              pop;
    logic [INST_W-1:0] head;

    // Sequencer state
    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [INST_W-1:0] issue_inst_q, issue_inst_d;
    logic              issue_valid_q;
    logic [5:0]        res_data_q;
    logic [3:0]        res_flag_q;
    logic              res_valid_q;
    logic              err_q, err_d;
    logic              capture;

    // A full FIFO refuses pushes even when the head is popped in the same cycle.
    assign o_ready = (count_q < CNT_W'(DEPTH));
    assign push    = i_valid && o_ready;
    assign head    = mem[rd_ptr_q];

    // Write accepted instructions into the FIFO storage
    // NOTE: the storage array has no reset; an entry is only read after it has been written,
    // and the occupancy count decides that, so clearing the array would cost logic and buy nothing.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= i_inst;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count separates full from empty
    // NOTE: sequential state is updated with non-blocking assignments only, so every flop
    // samples values from before the clock edge regardless of the order of the statements.
    always_ff @(posedge i_clk or posedge i_rsn) begin
        if (i_rsn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Next-state logic: pop and dispatch, completion wait with timeout, retire
    // NOTE: every signal driven here gets a default value first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        issue_inst_d = issue_inst_q;
        err_d        = err_q;
        pop          = 1'b0;
        capture      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                    // NOPs are dropped here and never reach the datapath.
                    if (head[INST_W-1 -: 3] != OPC_NOP) begin
                        issue_inst_d = head;
                        state_d      = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A completion on the final allowed cycle still wins over the timeout.
                if (i_exec_done) begin
                    capture = 1'b1;
                    state_d = S_RETIRE;
                end else if (timer_q == TMR_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_RETIRE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, timer and registered outputs
    always_ff @(posedge i_clk or posedge i_rsn) begin
        if (i_rsn) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            issue_inst_q  <= '0;
            issue_valid_q <= 1'b0;
            res_data_q    <= '0;
            res_flag_q    <= '0;
            res_valid_q   <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            issue_inst_q  <= issue_inst_d;
            err_q         <= err_d;
            // The issue strobe is high exactly while the sequencer sits in ISSUE.
            issue_valid_q <= (state_d == S_ISSUE);
            // The retire strobe follows the RETIRE cycle, one cycle after capture.
            res_valid_q   <= (state_q == S_RETIRE);
            if (capture) begin
                res_data_q <= i_data;
                res_flag_q <= i_flag;
            end
        end
    end

    assign o_issue_inst  = issue_inst_q;
    assign o_issue_valid = issue_valid_q;
    assign o_res_data    = res_data_q;
    assign o_res_flag    = res_flag_q;
    assign o_res_valid   = res_valid_q;
    assign o_err         = err_q;
    assign o_count       = count_q;
    assign o_busy        = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: doc/core_issue_ctrl.md
Name: core_issue_ctrl

Overview:
- Instruction sequencer in front of the CORE ALU/register datapath.
- Accepts 21-bit instructions from upstream via valid/ready and buffers them in a small FIFO.
- Issues one instruction at a time to the datapath and waits for its completion pulse.
- Captures the 6-bit signed result and 4-bit flags, presents them as a one-cycle retire strobe, and flags a sticky error on execution timeout.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
INST_W, 21, instruction width
TIMEOUT, 16, max cycles in WAIT before abort (>=2)

Ports:
i_clk  in  1  clock, rising edge
i_rsn  in  1  reset, asynchronous, active-high
i_inst  in  INST_W  instruction; opcode = i_inst[20:18]
i_valid  in  1  upstream instruction valid
o_ready  out  1  FIFO can accept (count < DEPTH)
o_issue_inst  out  INST_W  instruction presented to datapath
o_issue_valid  out  1  one-cycle issue strobe
i_exec_done  in  1  datapath completion pulse
i_data  in  6  signed datapath result
i_flag  in  4  datapath flags
o_res_data  out  6  captured result (signed)
o_res_flag  out  4  captured flags
o_res_valid  out  1  one-cycle retire strobe
o_busy  out  1  state != IDLE or FIFO non-empty
o_count  out  3  FIFO occupancy, 0..DEPTH
o_err  out  1  sticky timeout error

Behaviour:
- Reset (i_rsn=1, async):
  - FIFO empty, pointers 0, state IDLE, timer 0.
  - All registered outputs 0: o_issue_inst, o_issue_valid, o_res_*, o_err.
  - o_count=0, o_busy=0, o_ready=1.
  - Reset mid-operation discards queued and in-flight instructions. No result is ever produced for them.
- Accept:
  - Push on the rising edge where i_valid && o_ready.
  - o_ready is combinational: count < DEPTH.
  - When full, a simultaneous pop does not enable a push in that cycle (no bypass).
  - Instructions presented with o_ready=0 are not consumed; upstream must hold them.
- FSM states: IDLE, ISSUE, WAIT, RETIRE.
  - IDLE, FIFO non-empty: pop head.
    - Opcode 3'b000 (NOP): discard, stay IDLE; one pop per cycle.
    - Otherwise: latch into o_issue_inst, go to ISSUE.
  - ISSUE: o_issue_valid=1 for exactly this cycle; clear timer; go to WAIT.
  - WAIT: i_exec_done is sampled only in this state; timer increments each cycle.
    - On done: register i_data/i_flag into o_res_data/o_res_flag, go to RETIRE.
    - If timer reaches TIMEOUT-1 without done: set o_err=1, go to IDLE, no retire.
  - RETIRE: o_res_valid=1 for one cycle, go to IDLE.
- o_res_data/o_res_flag hold their last captured values until the next capture.
- o_issue_inst holds until the next issue.
- i_exec_done in IDLE, ISSUE or RETIRE is ignored.
- Latency, empty FIFO, state IDLE:
  - Accept at edge k -> o_issue_valid high between edges k+1 and k+2.
  - Done sampled at edge j -> o_res_valid high between edges j+1 and j+2.
- Throughput: max one instruction per 4 cycles with single-cycle datapath latency.
- FIFO order is strict FIFO. Pointers wrap modulo DEPTH; count distinguishes full from empty.
- o_err clears only on reset. Processing continues normally after a timeout.
- Signed handling: results pass through unmodified (two's complement, 6 bits); no sign extension or saturation.

Test Plan:
1. Reset, push inst opcode 3'b001, datapath returns done 3 cycles after o_issue_valid with i_data=6'h3B (-5) and i_flag=4'b1000 -> exactly one o_res_valid pulse with o_res_data=6'h3B and o_res_flag=4'h8; o_busy returns to 0 the cycle after RETIRE.
2. Hold i_valid for 6 distinct insts, done withheld -> first popped and issued, 4 more accepted, o_count=4, o_ready=0, 6th held. Then release done pulses -> issue order matches push order and the 6th is accepted once o_ready=1.
3. Push sequence NOP, A, NOP, B -> only A then B issued; NOPs produce no o_issue_valid and no o_res_valid; o_count drains to 0.
4. Issue an instruction, never assert done -> o_err=1 after 16 cycles in WAIT, no o_res_valid, next queued instruction issued; o_err stays 1.
5. Assert i_rsn while in WAIT with 3 queued, then pulse i_exec_done after release -> o_count=0, o_issue_valid=0, o_err=0 immediately on reset; no o_res_valid after release.
6. Pulse i_exec_done while IDLE and during the ISSUE cycle -> ignored; the result is captured only from a done pulse in WAIT.
